// File: rtl/rename_map_table_pkg.sv
// Shared types and sizing for the rename map table: dispatch packet layout,
// physical-register translation packet and the completion-match helper.
package rename_map_table_pkg;

    localparam int N_WAY     = 3;
    localparam int CDB_BITS  = 6;
    localparam int ARCH_REGS = 32;
    localparam int AREG_BITS = $clog2(ARCH_REGS);

    typedef logic [CDB_BITS-1:0]  ptag_t;
    typedef logic [AREG_BITS-1:0] areg_t;

    // valid/src1/src2/dest drive renaming; pc and fu_type travel on to the ROB
    typedef struct packed {
        logic        valid;
        areg_t       src1;
        areg_t       src2;
        areg_t       dest;
        logic [31:0] pc;
        logic [2:0]  fu_type;
    } DISPATCH_ROB_PACKET;

    typedef struct packed {
        ptag_t tag;
        logic  ready;
    } PR_PACKET;

    // Tag 0 on a CDB lane means "no completion", so it never matches.
    function automatic logic tag_completing(input ptag_t tag,
                                            input ptag_t [N_WAY-1:0] complete);
        logic hit;
        hit = 1'b0;
        for (int m = 0; m < N_WAY; m++) begin
            if ((complete[m] != '0) && (complete[m] == tag)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/rename_bypass.sv
// Intra-group dependency resolution: for each slot, finds the youngest older
// valid slot writing the same architectural register and forwards its new tag.
module rename_bypass
    import rename_map_table_pkg::*;
(
    input  logic  [N_WAY-1:0] i_valid,
    input  areg_t [N_WAY-1:0] i_src1,
    input  areg_t [N_WAY-1:0] i_src2,
    input  areg_t [N_WAY-1:0] i_dest,
    input  ptag_t [N_WAY-1:0] i_freelist,
    output logic  [N_WAY-1:0] o_src1_hit,
    output ptag_t [N_WAY-1:0] o_src1_tag,
    output logic  [N_WAY-1:0] o_src2_hit,
    output ptag_t [N_WAY-1:0] o_src2_tag,
    output logic  [N_WAY-1:0] o_dest_hit,
    output ptag_t [N_WAY-1:0] o_dest_tag
);

    always_comb begin
        o_src1_hit = '0;
        o_src1_tag = '0;
        o_src2_hit = '0;
        o_src2_tag = '0;
        o_dest_hit = '0;
        o_dest_tag = '0;
        for (int k = 1; k < N_WAY; k++) begin
            // Ascending scan: a later (younger) match overwrites an earlier one.
            for (int j = 0; j < k; j++) begin
                if (i_valid[j] && (i_dest[j] == i_src1[k])) begin
                    o_src1_hit[k] = 1'b1;
                    o_src1_tag[k] = i_freelist[j];
                end
                if (i_valid[j] && (i_dest[j] == i_src2[k])) begin
                    o_src2_hit[k] = 1'b1;
                    o_src2_tag[k] = i_freelist[j];
                end
                if (i_valid[j] && (i_dest[j] == i_dest[k])) begin
                    o_dest_hit[k] = 1'b1;
                    o_dest_tag[k] = i_freelist[j];
                end
            end
        end
    end

endmodule

// File: rtl/rename_map_table.sv
// Register-rename map table: per-architectural-register {physical tag, ready},
// zero-latency source/old-dest lookup with intra-group and CDB forwarding.
module rename_map_table
    import rename_map_table_pkg::*;
(
    input  logic                           clock,
    input  logic                           reset,
    input  DISPATCH_ROB_PACKET [N_WAY-1:0] dis_packet,
    input  ptag_t              [N_WAY-1:0] pr_freelist,
    input  ptag_t              [N_WAY-1:0] pr_reg_complete,
    output PR_PACKET           [N_WAY-1:0] pr_packet_out1,
    output PR_PACKET           [N_WAY-1:0] pr_packet_out2,
    output ptag_t              [N_WAY-1:0] pr_old
);

    logic  [N_WAY-1:0] w_valid;
    areg_t [N_WAY-1:0] w_src1;
    areg_t [N_WAY-1:0] w_src2;
    areg_t [N_WAY-1:0] w_dest;

    logic  [N_WAY-1:0] w_src1_hit;
    ptag_t [N_WAY-1:0] w_src1_byp;
    logic  [N_WAY-1:0] w_src2_hit;
    ptag_t [N_WAY-1:0] w_src2_byp;
    logic  [N_WAY-1:0] w_dest_hit;
    ptag_t [N_WAY-1:0] w_dest_byp;

    ptag_t w_tab_tag   [ARCH_REGS];
    logic  w_tab_ready [ARCH_REGS];
    logic  w_tab_fwd   [ARCH_REGS];

    logic  w_unused_rob_fields;

    genvar gi;

    generate
        for (gi = 0; gi < N_WAY; gi++) begin : g_unpack
            assign w_valid[gi] = dis_packet[gi].valid;
            assign w_src1[gi]  = dis_packet[gi].src1;
            assign w_src2[gi]  = dis_packet[gi].src2;
            assign w_dest[gi]  = dis_packet[gi].dest;
        end
    endgenerate

    assign w_unused_rob_fields = ^{dis_packet[0].pc, dis_packet[0].fu_type,
                                   dis_packet[1].pc, dis_packet[1].fu_type,
                                   dis_packet[2].pc, dis_packet[2].fu_type};

    rename_bypass u_bypass (
        .i_valid    (w_valid),
        .i_src1     (w_src1),
        .i_src2     (w_src2),
        .i_dest     (w_dest),
        .i_freelist (pr_freelist),
        .o_src1_hit (w_src1_hit),
        .o_src1_tag (w_src1_byp),
        .o_src2_hit (w_src2_hit),
        .o_src2_tag (w_src2_byp),
        .o_dest_hit (w_dest_hit),
        .o_dest_tag (w_dest_byp)
    );

    generate
        for (gi = 0; gi < ARCH_REGS; gi++) begin : g_entry
            ptag_t r_tag;
            logic  r_ready;
            logic  w_wr_en;
            ptag_t w_wr_tag;

            // Youngest valid slot targeting this register supplies the new tag.
            always_comb begin
                w_wr_en  = 1'b0;
                w_wr_tag = '0;
                for (int k = 0; k < N_WAY; k++) begin
                    if (w_valid[k] && (w_dest[k] == areg_t'(gi))) begin
                        w_wr_en  = 1'b1;
                        w_wr_tag = pr_freelist[k];
                    end
                end
            end

            assign w_tab_fwd[gi]   = tag_completing(r_tag, pr_reg_complete);
            assign w_tab_tag[gi]   = r_tag;
            assign w_tab_ready[gi] = r_ready;

            // A rename in the same cycle wins over a completion of the old tag.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_tag   <= ptag_t'(gi);
                    r_ready <= 1'b1;
                end else if (w_wr_en) begin
                    r_tag   <= w_wr_tag;
                    r_ready <= 1'b0;
                end else if (w_tab_fwd[gi]) begin
                    r_ready <= 1'b1;
                end
            end
        end
    endgenerate

    generate
        for (gi = 0; gi < N_WAY; gi++) begin : g_lookup
            assign pr_packet_out1[gi] = w_src1_hit[gi]
                ? PR_PACKET'{tag: w_src1_byp[gi], ready: 1'b0}
                : PR_PACKET'{tag: w_tab_tag[w_src1[gi]],
                             ready: w_tab_ready[w_src1[gi]] | w_tab_fwd[w_src1[gi]]};

            assign pr_packet_out2[gi] = w_src2_hit[gi]
                ? PR_PACKET'{tag: w_src2_byp[gi], ready: 1'b0}
                : PR_PACKET'{tag: w_tab_tag[w_src2[gi]],
                             ready: w_tab_ready[w_src2[gi]] | w_tab_fwd[w_src2[gi]]};

            assign pr_old[gi] = w_dest_hit[gi] ? w_dest_byp[gi] : w_tab_tag[w_dest[gi]];
        end
    endgenerate

endmodule

// File: tb/tb_rename_map_table.sv
// Directed plus randomized checks of rename_map_table against a sequential
// behavioural model of the architectural-to-physical mapping.
module tb_rename_map_table;
    import rename_map_table_pkg::*;

    logic                           clock;
    logic                           reset;
    DISPATCH_ROB_PACKET [N_WAY-1:0] dis_packet;
    ptag_t              [N_WAY-1:0] pr_freelist;
    ptag_t              [N_WAY-1:0] pr_reg_complete;
    PR_PACKET           [N_WAY-1:0] pr_packet_out1;
    PR_PACKET           [N_WAY-1:0] pr_packet_out2;
    ptag_t              [N_WAY-1:0] pr_old;

    int vectors;
    int miscompares;

    int m_tag [ARCH_REGS];
    bit m_rdy [ARCH_REGS];

    rename_map_table dut (
        .clock           (clock),
        .reset           (reset),
        .dis_packet      (dis_packet),
        .pr_freelist     (pr_freelist),
        .pr_reg_complete (pr_reg_complete),
        .pr_packet_out1  (pr_packet_out1),
        .pr_packet_out2  (pr_packet_out2),
        .pr_old          (pr_old)
    );

    always #5 clock = ~clock;

    function automatic void model_reset();
        for (int i = 0; i < ARCH_REGS; i++) begin
            m_tag[i] = i;
            m_rdy[i] = 1'b1;
        end
    endfunction

    function automatic bit completing(input int t);
        for (int m = 0; m < N_WAY; m++)
            if (pr_reg_complete[m] != 0 && int'(pr_reg_complete[m]) == t) return 1'b1;
        return 1'b0;
    endfunction

    // Source translation as {tag, ready} packed into an int: tag*2 + ready.
    function automatic int exp_src(input int k, input int s);
        int tag;
        bit rdy;
        tag = m_tag[s];
        rdy = m_rdy[s] || completing(tag);
        for (int j = 0; j < k; j++) begin
            if (dis_packet[j].valid && int'(dis_packet[j].dest) == s) begin
                tag = int'(pr_freelist[j]);
                rdy = 1'b0;
            end
        end
        return tag * 2 + int'(rdy);
    endfunction

    function automatic int exp_old(input int k);
        int d;
        int tag;
        d   = int'(dis_packet[k].dest);
        tag = m_tag[d];
        for (int j = 0; j < k; j++)
            if (dis_packet[j].valid && int'(dis_packet[j].dest) == d) tag = int'(pr_freelist[j]);
        return tag;
    endfunction

    // Clock edge: completions first, then renames in program order.
    function automatic void model_update();
        for (int i = 0; i < ARCH_REGS; i++)
            if (completing(m_tag[i])) m_rdy[i] = 1'b1;
        for (int k = 0; k < N_WAY; k++) begin
            if (dis_packet[k].valid) begin
                m_tag[int'(dis_packet[k].dest)] = int'(pr_freelist[k]);
                m_rdy[int'(dis_packet[k].dest)] = 1'b0;
            end
        end
    endfunction

    task automatic cmp(input string name, input int k, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s[%0d] observed=%0d expected=%0d", name, k, obs, exp);
        end
    endtask

    task automatic expect_pkt(input string name, input int k, input PR_PACKET obs,
                              input int tag, input int rdy);
        cmp(name, k, int'({25'd0, obs}), tag * 2 + rdy);
    endtask

    task automatic expect_old(input string name, input int k, input int tag);
        cmp(name, k, int'({26'd0, pr_old[k]}), tag);
    endtask

    task automatic check_model(input string name);
        for (int k = 0; k < N_WAY; k++) begin
            cmp({name, "_out1"}, k, int'({25'd0, pr_packet_out1[k]}),
                exp_src(k, int'(dis_packet[k].src1)));
            cmp({name, "_out2"}, k, int'({25'd0, pr_packet_out2[k]}),
                exp_src(k, int'(dis_packet[k].src2)));
            cmp({name, "_old"}, k, int'({26'd0, pr_old[k]}), exp_old(k));
        end
        $display("step %-8s t=%0t vectors=%0d miscompares=%0d", name, $time, vectors, miscompares);
    endtask

    task automatic set_slot(input int k, input bit v, input int s1, input int s2,
                            input int d, input int fl);
        dis_packet[k].valid   = v;
        dis_packet[k].src1    = areg_t'(s1);
        dis_packet[k].src2    = areg_t'(s2);
        dis_packet[k].dest    = areg_t'(d);
        dis_packet[k].pc      = $urandom;
        dis_packet[k].fu_type = 3'($urandom);
        pr_freelist[k]        = ptag_t'(fl);
    endtask

    task automatic begin_step();
        @(negedge clock);
        pr_reg_complete = '0;
        for (int k = 0; k < N_WAY; k++) set_slot(k, 1'b0, 0, 0, 0, 0);
    endtask

    task automatic end_step(input string name);
        check_model(name);
        @(posedge clock);
        model_update();
    endtask

    initial begin
        clock           = 1'b0;
        reset           = 1'b0;
        dis_packet      = '0;
        pr_freelist     = '0;
        pr_reg_complete = '0;
        vectors         = 0;
        miscompares     = 0;
        model_reset();
        repeat (2) @(negedge clock);

        // Identity map right after reset release
        begin_step();
        reset = 1'b1;
        for (int k = 0; k < N_WAY; k++) set_slot(k, 1'b1, k, k + 1, 20 + k, 50 + k);
        #1;
        for (int k = 0; k < N_WAY; k++) begin
            expect_pkt("rst_out1", k, pr_packet_out1[k], k, 1);
            expect_pkt("rst_out2", k, pr_packet_out2[k], k + 1, 1);
            expect_old("rst_old", k, 20 + k);
        end
        end_step("reset");

        // Group A
        begin_step();
        set_slot(0, 1'b1, 0, 1, 2, 33);
        set_slot(1, 1'b1, 3, 4, 5, 34);
        set_slot(2, 1'b1, 6, 7, 2, 35);
        #1;
        expect_pkt("A_out1", 0, pr_packet_out1[0], 0, 1);
        expect_pkt("A_out2", 0, pr_packet_out2[0], 1, 1);
        expect_pkt("A_out1", 1, pr_packet_out1[1], 3, 1);
        expect_pkt("A_out2", 1, pr_packet_out2[1], 4, 1);
        expect_pkt("A_out1", 2, pr_packet_out1[2], 6, 1);
        expect_pkt("A_out2", 2, pr_packet_out2[2], 7, 1);
        expect_old("A_old", 0, 2);
        expect_old("A_old", 1, 5);
        expect_old("A_old", 2, 33);
        end_step("groupA");

        // Group B
        begin_step();
        set_slot(0, 1'b1, 1, 2, 3, 36);
        set_slot(1, 1'b1, 3, 4, 5, 37);
        set_slot(2, 1'b1, 7, 5, 5, 38);
        #1;
        expect_pkt("B_out1", 0, pr_packet_out1[0], 1, 1);
        expect_pkt("B_out2", 0, pr_packet_out2[0], 35, 0);
        expect_pkt("B_out1", 1, pr_packet_out1[1], 36, 0);
        expect_pkt("B_out2", 1, pr_packet_out2[1], 4, 1);
        expect_pkt("B_out1", 2, pr_packet_out1[2], 7, 1);
        expect_pkt("B_out2", 2, pr_packet_out2[2], 37, 0);
        expect_old("B_old", 0, 3);
        expect_old("B_old", 1, 34);
        expect_old("B_old", 2, 37);
        end_step("groupB");

        // Group C with stale completions 33/34
        begin_step();
        pr_reg_complete[0] = 6'd33;
        pr_reg_complete[1] = 6'd34;
        set_slot(0, 1'b1, 5, 6, 8, 39);
        set_slot(1, 1'b1, 2, 3, 4, 40);
        set_slot(2, 1'b1, 6, 7, 0, 41);
        #1;
        expect_pkt("C_out1", 0, pr_packet_out1[0], 38, 0);
        expect_pkt("C_out2", 0, pr_packet_out2[0], 6, 1);
        expect_pkt("C_out1", 1, pr_packet_out1[1], 35, 0);
        expect_pkt("C_out2", 1, pr_packet_out2[1], 36, 0);
        expect_pkt("C_out1", 2, pr_packet_out1[2], 6, 1);
        expect_pkt("C_out2", 2, pr_packet_out2[2], 7, 1);
        expect_old("C_old", 0, 8);
        expect_old("C_old", 1, 4);
        expect_old("C_old", 2, 0);
        end_step("groupC");

        // Same-cycle completion forwarding, then the stored ready bit
        begin_step();
        pr_reg_complete[0] = 6'd36;
        set_slot(0, 1'b1, 3, 0, 9, 42);
        #1;
        expect_pkt("fwd_now", 0, pr_packet_out1[0], 36, 1);
        end_step("fwd0");
        begin_step();
        set_slot(0, 1'b1, 3, 0, 10, 43);
        #1;
        expect_pkt("fwd_held", 0, pr_packet_out1[0], 36, 1);
        end_step("fwd1");

        // Rename and completion on x2 in one cycle: rename wins
        begin_step();
        pr_reg_complete[0] = 6'd35;
        set_slot(0, 1'b1, 2, 2, 2, 39);
        #1;
        expect_pkt("simul_pre", 0, pr_packet_out1[0], 35, 1);
        end_step("simul");
        begin_step();
        set_slot(0, 1'b0, 2, 2, 2, 60);
        #1;
        expect_pkt("simul_post", 0, pr_packet_out1[0], 39, 0);
        end_step("idle0");
        begin_step();
        set_slot(0, 1'b0, 2, 2, 2, 61);
        #1;
        expect_pkt("idle_hold", 0, pr_packet_out1[0], 39, 0);
        end_step("idle1");

        // Asynchronous reset mid-stream with a valid packet present
        begin_step();
        set_slot(0, 1'b1, 2, 8, 2, 62);
        reset = 1'b0;
        #1;
        model_reset();
        expect_pkt("midrst_out1", 0, pr_packet_out1[0], 2, 1);
        expect_pkt("midrst_out2", 0, pr_packet_out2[0], 8, 1);
        expect_old("midrst_old", 0, 2);
        check_model("midrst");
        @(posedge clock);
        begin_step();
        reset = 1'b1;
        set_slot(0, 1'b0, 2, 8, 2, 63);
        #1;
        expect_pkt("postrst_out1", 0, pr_packet_out1[0], 2, 1);
        end_step("postrst");

        // Randomized traffic; completions biased toward tags live in the table
        for (int i = 0; i < 400; i++) begin
            begin_step();
            for (int k = 0; k < N_WAY; k++) begin
                set_slot(k, ($urandom_range(0, 3) != 0),
                         int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                         int'($urandom_range(0, 7)), int'($urandom_range(1, 63)));
                case ($urandom_range(0, 2))
                    0:       pr_reg_complete[k] = '0;
                    1:       pr_reg_complete[k] = ptag_t'(m_tag[$urandom_range(0, 31)]);
                    default: pr_reg_complete[k] = ptag_t'($urandom_range(0, 63));
                endcase
            end
            #1;
            end_step("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rename_map_table.md
Name: rename_map_table

Overview:
- Register-rename map table for the N_WAY superscalar dispatch stage.
- Holds one entry per architectural register: the current physical tag plus a ready bit.
- Each cycle it renames up to N_WAY dispatched instructions. Sources are translated to physical tags with ready status. Each destination gets the tag supplied by the free list, and the displaced (old) tag is reported to the ROB.
- Completion tags broadcast on the CDB set the ready bits.

Parameters:
- N_WAY, 3, dispatch/rename width (package constant).
- CDB_BITS, 6, physical tag width; 64 physical registers (package constant).
- ARCH_REGS, 32, architectural registers; index width 5 (package constant).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- dis_packet  in  N_WAY x DISPATCH_ROB_PACKET  per slot: valid, src1[4:0], src2[4:0], dest[4:0]. Slot 0 is oldest.
- pr_freelist  in  N_WAY x CDB_BITS  new physical tag for each slot's dest.
- pr_reg_complete  in  N_WAY x CDB_BITS  completed tags from the CDB; 0 means no completion.
- pr_packet_out1  out  N_WAY x PR_PACKET  src1 translation {tag, ready}.
- pr_packet_out2  out  N_WAY x PR_PACKET  src2 translation {tag, ready}.
- pr_old  out  N_WAY x CDB_BITS  previous mapping of each slot's dest.

Behaviour:
- Reset (reset=0, asynchronous): entry i = {tag=i, ready=1} for i in 0..31.
- All outputs are combinational from table state and current inputs (zero latency). The table updates on the rising clock edge.
- Source lookup for slot k, src s:
  - If any older valid slot j<k in the same group has dest==s, use the youngest such j: {pr_freelist[j], ready=0}.
  - Otherwise use the table entry for s. Its ready bit is 1 if the stored ready is 1 or if the stored tag equals any nonzero pr_reg_complete[m] this cycle (same-cycle forwarding).
- pr_old[k]:
  - If an older valid slot j<k has dest==dest[k], use the youngest such j: pr_freelist[j].
  - Otherwise use the table tag of dest[k].
- Invalid slots: outputs are still computed, but the slot neither updates the table nor acts as a bypass source.
- Clock edge, completion: for every nonzero pr_reg_complete[m], each entry whose tag matches gets ready=1. Tags are unique, so at most one entry matches.
- Clock edge, rename: for each valid slot, table[dest] = {pr_freelist[k], 0}. When several slots share a dest, the youngest slot wins.
- Rename overrides completion on the same entry in the same cycle; the new tag is not ready.
- Completion tags that match no entry (tag already overwritten) have no effect.
- dest=0 is renamed like any other register. Upstream decode marks writes to x0 as invalid.
- Reset asserted mid-operation restores the identity map immediately, regardless of dis_packet.

Decomposition:
- Shared package holds:
  - N_WAY, CDB_BITS, ARCH_REGS.
  - DISPATCH_ROB_PACKET (valid, src1, src2, dest, plus other ROB fields this block ignores).
  - PR_PACKET {tag[CDB_BITS-1:0], ready}.
- No sub-module is required. The intra-group bypass/priority logic may optionally be factored into a combinational helper, rename_bypass.

Test Plan:
- Reset check: after reset release, with all slots valid and src1=k, src2=k+1 for any k, every output = {k,1},{k+1,1} and pr_old[k] = dest.
- Group A, fl 33/34/35: slot0 (0,1→2), slot1 (3,4→5), slot2 (6,7→2).
  - Required: out1/out2 = {0,1}{1,1}, {3,1}{4,1}, {6,1}{7,1}.
  - Required: pr_old = 2, 5, 33 (intra-group dest bypass).
- Group B next cycle, fl 36/37/38: slot0 (1,2→3), slot1 (3,4→5), slot2 (7,5→5).
  - Required: slot0 {1,1}{35,0}; slot1 {36,0}{4,1}; slot2 {7,1}{37,0}.
  - Required: pr_old = 3, 34, 37.
- Group C next cycle, complete 33/34/0, fl 39/40/41: slot0 (5,6→8), slot1 (2,3→4), slot2 (6,7→0).
  - Required: slot0 {38,0}{6,1}; slot1 {35,0}{36,0}; slot2 {6,1}{7,1}.
  - Required: pr_old = 8, 4, 0. Stale completions 33/34 have no effect.
- Completion forwarding: complete=36 with slot0 src1=3 valid → out1 {36,1} in the same cycle; the next cycle, with no completion, still {36,1}.
- Simultaneous events: complete=35 while slot0 renames dest=2 to 39 → next cycle x2 reads {39,0}. Then with all valid=0 for one cycle, the table is unchanged. Then asserting reset=0 mid-stream → x2 reads {2,1}.
